// File: rtl/fp_mul_pkg.sv
// Shared definitions for the floating-point multiplier round/pack stage.
// Holds the format constants, the stage-1 payload struct, the rounding-mode
// enum and the normalise helper used by stage 1.
// Optional build macro FP_MUL_RTZ_EN (round-toward-zero support) is handled
// in the interface and top module; nothing here depends on it.
package fp_mul_pkg;

  localparam int EXP_W   = 8;          // exponent field width
  localparam int MAN_W   = 24;         // significand width incl. hidden bit
  localparam int BIAS    = 127;        // exponent bias (input arrives rebiased)
  localparam int EXP_MAX = 255;        // all-ones exponent: infinity
  localparam int EXP_EW  = EXP_W + 2;  // signed working exponent width
  localparam int PROD_W  = 2 * MAN_W;  // raw significand product width
  localparam int FRAC_W  = MAN_W - 1;  // stored fraction width

  localparam logic [EXP_EW-1:0] EXP_OVF = EXP_EW'(EXP_MAX);

  typedef enum logic {
    RND_RNE = 1'b0,
    RND_RTZ = 1'b1
  } rnd_mode_e;

  // Stage-1 payload: normalised significand plus round bits.
  // exp is a two's-complement value; compare it with $signed().
  typedef struct packed {
    logic              sign;
    logic [EXP_EW-1:0] exp;
    logic [MAN_W-1:0]  sig;
    logic              guard;
    logic              sticky;
  } s1_payload_t;

  // Select the top MAN_W bits of the product depending on whether the
  // product landed in [2,4) (top bit set) or [1,2).
  function automatic s1_payload_t normalise(input logic              sign,
                                            input logic [EXP_EW-1:0] exp,
                                            input logic [PROD_W-1:0] man);
    s1_payload_t p;
    p.sign = sign;
    if (man[PROD_W-1]) begin
      p.sig    = man[PROD_W-1 -: MAN_W];
      p.guard  = man[MAN_W-1];
      p.sticky = |man[MAN_W-2:0];
      p.exp    = exp + {{(EXP_EW-1){1'b0}}, 1'b1};
    end else begin
      p.sig    = man[PROD_W-2 -: MAN_W];
      p.guard  = man[MAN_W-2];
      p.sticky = |man[MAN_W-3:0];
      p.exp    = exp;
    end
    return p;
  endfunction

endpackage

// File: rtl/fp_mul_round_pack_if.sv
// Handshake/data bundle for fp_mul_round_pack.
//   slave  : view of the round/pack stage (consumes operands, produces result)
//   master : view of the environment driving operands and taking results
// With FP_MUL_RTZ_EN defined an extra rnd_mode signal travels with the beat.
interface fp_mul_round_pack_if;
  import fp_mul_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic                   sign_in;
  logic [EXP_EW-1:0]      exp_in;
  logic [PROD_W-1:0]      man_in;
`ifdef FP_MUL_RTZ_EN
  logic                   rnd_mode;
`endif
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W-1:0] result;
  logic                   flag_ovf;
  logic                   flag_unf;
  logic                   flag_inx;

  modport slave (
    input  in_valid, sign_in, exp_in, man_in,
`ifdef FP_MUL_RTZ_EN
    input  rnd_mode,
`endif
    input  out_ready,
    output in_ready, out_valid, result, flag_ovf, flag_unf, flag_inx
  );

  modport master (
    output in_valid, sign_in, exp_in, man_in,
`ifdef FP_MUL_RTZ_EN
    output rnd_mode,
`endif
    output out_ready,
    input  in_ready, out_valid, result, flag_ovf, flag_unf, flag_inx
  );

endinterface

// File: rtl/fp_round_rne.sv
// Combinational rounding of a normalised significand.
// Ports: sig/guard/sticky/exp in, mode (RNE or RTZ) in;
//        frac (rounded stored fraction), exp_out (exponent after carry),
//        inexact (discarded bits were nonzero) out.
module fp_round_rne
  import fp_mul_pkg::*;
(
  input  logic [MAN_W-1:0]  sig,
  input  logic              guard,
  input  logic              sticky,
  input  logic [EXP_EW-1:0] exp,
  input  rnd_mode_e         mode,
  output logic [FRAC_W-1:0] frac,
  output logic [EXP_EW-1:0] exp_out,
  output logic              inexact
);

  logic inc_s;
  logic carry_s;

  // Round-to-nearest-even increment; round-toward-zero never increments.
  always_comb begin
    inc_s = 1'b0;
    if (mode == RND_RTZ) begin
      inc_s = 1'b0;
    end else begin
      inc_s = guard && (sticky || sig[0]);
    end
  end

  // A carry out of sig+inc only happens for an all-ones significand; the
  // fraction then wraps to zero, which is exactly the renormalised 1.000..0.
  assign carry_s = inc_s && (&sig);
  assign frac    = sig[FRAC_W-1:0] + {{(FRAC_W-1){1'b0}}, inc_s};
  assign exp_out = exp + {{(EXP_EW-1){1'b0}}, carry_s};
  assign inexact = guard || sticky;

endmodule

// File: rtl/fp_mul_round_pack.sv
// Final stage of the single-precision multiplier: normalise (S1), then
// round, range-check and pack the IEEE-754 word (S2), with a valid/ready
// two-stage pipeline.
// Ports: clk, reset (synchronous, active-high), bus (fp_mul_round_pack_if
//        slave: operand beat in, packed result and ovf/unf/inx flags out).
// Build macro FP_MUL_RTZ_EN: adds per-beat rnd_mode (1 = round toward zero,
// overflow saturates to the largest finite value).
module fp_mul_round_pack
  import fp_mul_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  fp_mul_round_pack_if.slave  bus
);

  logic                   s1_valid_r;
  logic                   s2_valid_r;
  s1_payload_t            s1_pay_r;
  s1_payload_t            s1_pay_s;
  rnd_mode_e              s1_mode_s;
  logic                   s1_advance_s;
  logic                   in_ready_s;

  logic [FRAC_W-1:0]      rnd_frac_s;
  logic [EXP_EW-1:0]      rnd_exp_s;
  logic                   rnd_inx_s;
  logic                   zero_s;

  logic [EXP_W+MAN_W-1:0] res_s;
  logic                   ovf_s;
  logic                   unf_s;
  logic                   inx_s;

  logic [EXP_W+MAN_W-1:0] res_r;
  logic                   ovf_r;
  logic                   unf_r;
  logic                   inx_r;

  assign s1_pay_s     = normalise(bus.sign_in, bus.exp_in, bus.man_in);
  assign s1_advance_s = !s2_valid_r || bus.out_ready;
  assign in_ready_s   = !s1_valid_r || s1_advance_s;

`ifdef FP_MUL_RTZ_EN
  rnd_mode_e s1_mode_r;

  // Rounding mode rides along with the stage-1 payload.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_mode_r <= RND_RNE;
    end else if (in_ready_s && bus.in_valid) begin
      s1_mode_r <= rnd_mode_e'(bus.rnd_mode);
    end
  end

  assign s1_mode_s = s1_mode_r;
`else
  assign s1_mode_s = RND_RNE;
`endif

  fp_round_rne u_round (
    .sig     (s1_pay_r.sig),
    .guard   (s1_pay_r.guard),
    .sticky  (s1_pay_r.sticky),
    .exp     (s1_pay_r.exp),
    .mode    (s1_mode_s),
    .frac    (rnd_frac_s),
    .exp_out (rnd_exp_s),
    .inexact (rnd_inx_s)
  );

  // With the top bit clear, sig/guard/sticky together cover every product
  // bit, so all three being zero means the whole product was zero.
  assign zero_s = (s1_pay_r.sig == {MAN_W{1'b0}}) && !s1_pay_r.guard && !s1_pay_r.sticky;

  // Range check after rounding and pack; zero product wins over everything.
  always_comb begin
    res_s = {(EXP_W+MAN_W){1'b0}};
    ovf_s = 1'b0;
    unf_s = 1'b0;
    inx_s = 1'b0;
    if (zero_s) begin
      res_s = {s1_pay_r.sign, {(EXP_W+FRAC_W){1'b0}}};
    end else if ($signed(rnd_exp_s) >= $signed(EXP_OVF)) begin
      ovf_s = 1'b1;
      inx_s = 1'b1;
      if (s1_mode_s == RND_RTZ) begin
        res_s = {s1_pay_r.sign, {(EXP_W-1){1'b1}}, 1'b0, {FRAC_W{1'b1}}};
      end else begin
        res_s = {s1_pay_r.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end
    end else if (rnd_exp_s[EXP_EW-1] || (rnd_exp_s == {EXP_EW{1'b0}})) begin
      // Flush to signed zero; no subnormals are produced.
      unf_s = 1'b1;
      inx_s = 1'b1;
      res_s = {s1_pay_r.sign, {(EXP_W+FRAC_W){1'b0}}};
    end else begin
      inx_s = rnd_inx_s;
      res_s = {s1_pay_r.sign, rnd_exp_s[EXP_W-1:0], rnd_frac_s};
    end
  end

  // Pipeline registers: S1 loads when it is empty or draining, S2 loads
  // when it is empty or the consumer takes the current result.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      s1_pay_r   <= '0;
      res_r      <= {(EXP_W+MAN_W){1'b0}};
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
      inx_r      <= 1'b0;
    end else begin
      if (in_ready_s) begin
        s1_valid_r <= bus.in_valid;
        if (bus.in_valid) begin
          s1_pay_r <= s1_pay_s;
        end
      end
      if (s1_advance_s) begin
        s2_valid_r <= s1_valid_r;
        if (s1_valid_r) begin
          res_r <= res_s;
          ovf_r <= ovf_s;
          unf_r <= unf_s;
          inx_r <= inx_s;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_valid_r;
  assign bus.result    = res_r;
  assign bus.flag_ovf  = ovf_r;
  assign bus.flag_unf  = unf_r;
  assign bus.flag_inx  = inx_r;

endmodule

// File: tb/tb_fp_mul_round_pack.sv
// Self-checking bench for fp_mul_round_pack: directed corner cases,
// back-pressure, mid-stream reset and a randomized stream scored against a
// remainder-based rounding model.
module tb_fp_mul_round_pack;
  import fp_mul_pkg::*;

  logic clk = 1'b0;
  logic reset;

  fp_mul_round_pack_if bus ();

  fp_mul_round_pack dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks  = 0;
  int          n_fail    = 0;
  int          n_drained = 0;
  int          n_stale   = 0;
  logic        last_acc  = 1'b0;
  logic        hold_prev = 1'b0;
  logic [34:0] prev_out;
  logic [34:0] sb_q[$];
  int          cur_e;
  logic        cur_rtz;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Reference: {ovf, unf, inx, result}, computed from the remainder of the
  // product below the kept significand.
  function automatic logic [34:0] ref_model(input logic sgn, input int e_in,
                                            input logic [47:0] man, input logic rtz);
    longint unsigned m, sig, rem, half;
    int sh, e;
    logic ovf, unf, inx;
    logic [31:0] res;
    ovf = 1'b0;
    unf = 1'b0;
    if (man == 48'h0) return {3'b000, sgn, 31'h0};
    m    = {16'h0, man};
    sh   = man[47] ? 24 : 23;
    e    = e_in + (man[47] ? 1 : 0);
    sig  = m >> sh;
    rem  = m - (sig << sh);
    half = 64'd1 << (sh - 1);
    inx  = (rem != 64'd0);
    if (!rtz && ((rem > half) || ((rem == half) && sig[0]))) sig = sig + 64'd1;
    if (sig == (64'd1 << 24)) begin
      sig = 64'd1 << 23;
      e   = e + 1;
    end
    if (e >= EXP_MAX) begin
      ovf = 1'b1;
      inx = 1'b1;
      res = rtz ? {sgn, 8'hFE, 23'h7FFFFF} : {sgn, 8'hFF, 23'h0};
    end else if (e <= 0) begin
      unf = 1'b1;
      inx = 1'b1;
      res = {sgn, 31'h0};
    end else begin
      res = {sgn, e[7:0], sig[22:0]};
    end
    return {ovf, unf, inx, res};
  endfunction

  task automatic drive_beat(input logic sgn, input int e, input logic [47:0] man, input logic rtz);
    logic [31:0] ev;
    ev          = e;
    cur_e       = e;
    bus.sign_in = sgn;
    bus.exp_in  = ev[EXP_EW-1:0];
    bus.man_in  = man;
`ifdef FP_MUL_RTZ_EN
    bus.rnd_mode = rtz;
    cur_rtz      = rtz;
`else
    cur_rtz      = 1'b0 & rtz;
`endif
    bus.in_valid = 1'b1;
  endtask

  task automatic new_beat();
    longint unsigned ma, mb, p;
    logic [47:0] man;
    int e, cat;
    ma  = {40'h0, 24'($urandom_range(0, 24'h7FFFFF))} | 64'h800000;
    mb  = {40'h0, 24'($urandom_range(0, 24'h7FFFFF))} | 64'h800000;
    p   = ma * mb;
    man = p[47:0];
    cat = $urandom_range(0, 15);
    if (cat == 0) man = 48'h0;
    else if (cat < 3) begin
      if (man[47]) man[23:0] = 24'h800000;
      else         man[22:0] = 23'h400000;
    end
    cat = $urandom_range(0, 3);
    if (cat == 0)      e = $urandom_range(0, 6) - 3;
    else if (cat == 1) e = $urandom_range(250, 256);
    else               e = $urandom_range(0, 510) - 127;
    drive_beat($urandom_range(0, 1), e, man, $urandom_range(0, 1));
  endtask

  // One clock: sample at the falling edge, score, then return 1 after the
  // next rising edge so callers can drive the following cycle.
  task automatic tick();
    logic acc, drn;
    logic [34:0] want, now;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    drn = bus.out_valid && bus.out_ready;
    now = {bus.flag_ovf, bus.flag_unf, bus.flag_inx, bus.result};
    if (hold_prev) begin
      check("hold_valid", bus.out_valid, 1'b1);
      check("hold_data", now, prev_out);
    end
    hold_prev = bus.out_valid && !bus.out_ready;
    prev_out  = now;
    if (drn) begin
      n_drained++;
      if (sb_q.size() == 0) begin
        n_stale++;
      end else begin
        want = sb_q.pop_front();
        check("result", bus.result, want[31:0]);
        check("flags", {bus.flag_ovf, bus.flag_unf, bus.flag_inx}, want[34:32]);
      end
    end
    if (acc) sb_q.push_back(ref_model(bus.sign_in, cur_e, bus.man_in, cur_rtz));
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic sgn, input int e, input logic [47:0] man,
                          input logic rtz, input logic [31:0] w_res, input logic [2:0] w_flg);
    bus.out_ready = 1'b1;
    drive_beat(sgn, e, man, rtz);
    tick();
    bus.in_valid = 1'b0;
    check({tag, "_acc"}, last_acc, 1'b1);
    check({tag, "_lat1"}, bus.out_valid, 1'b0);
    tick();
    check({tag, "_lat2"}, bus.out_valid, 1'b1);
    check({tag, "_res"}, bus.result, w_res);
    check({tag, "_flg"}, {bus.flag_ovf, bus.flag_unf, bus.flag_inx}, w_flg);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc, d0, s0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.sign_in   = 1'b0;
    bus.exp_in    = '0;
    bus.man_in    = '0;
    bus.out_ready = 1'b0;
`ifdef FP_MUL_RTZ_EN
    bus.rnd_mode  = 1'b0;
`endif
    cur_e   = 0;
    cur_rtz = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_result", bus.result, 32'h0);
    check("rst_flags", {bus.flag_ovf, bus.flag_unf, bus.flag_inx}, 3'b000);
    check("rst_in_ready", bus.in_ready, 1'b1);
    reset = 1'b0;

    directed("normal", 1'b0, BIAS, 48'h9000_0000_0000, 1'b0, 32'h4010_0000, 3'b000);
    directed("tie_carry", 1'b0, 127, 48'h7FFF_FFC0_0000, 1'b0, 32'h4000_0000, 3'b001);
    directed("ovf", 1'b0, 254, 48'h8000_0000_0000, 1'b0, 32'h7F80_0000, 3'b101);
`ifdef FP_MUL_RTZ_EN
    directed("ovf_rtz", 1'b0, 254, 48'h8000_0000_0000, 1'b1, 32'h7F7F_FFFF, 3'b101);
`endif
    directed("unf", 1'b1, 0, 48'h4000_0000_0000, 1'b0, 32'h8000_0000, 3'b011);
    directed("zero", 1'b1, 200, 48'h0, 1'b0, 32'h8000_0000, 3'b000);

    // Back-pressure: consumer stalls for three cycles while four beats queue.
    bus.out_ready = 1'b0;
    n_acc = 0;
    d0    = n_drained;
    new_beat();
    repeat (3) begin
      tick();
      if (last_acc) begin
        n_acc++;
        if (n_acc < 4) new_beat();
        else bus.in_valid = 1'b0;
      end
    end
    check("bp_accepted", n_acc, 2);
    check("bp_in_ready", bus.in_ready, 1'b0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (n_drained - d0 >= 4) break;
      tick();
      if (last_acc) begin
        n_acc++;
        if (n_acc < 4) new_beat();
        else bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    check("bp_drained", n_drained - d0, 4);

    // Reset with both stages holding beats: nothing may come out afterwards.
    bus.out_ready = 1'b0;
    new_beat();
    tick();
    new_beat();
    tick();
    bus.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", bus.out_valid, 1'b0);
    check("mid_rst_result", bus.result, 32'h0);
    check("mid_rst_in_ready", bus.in_ready, 1'b1);
    sb_q.delete();
    hold_prev     = 1'b0;
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    s0 = n_stale;
    repeat (6) tick();
    check("mid_rst_no_stale", n_stale - s0, 0);

    // Randomized stream with random idle cycles and back-pressure.
    bus.in_valid = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!bus.in_valid || last_acc) begin
        if ($urandom_range(0, 4) != 0) new_beat();
        else bus.in_valid = 1'b0;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (sb_q.size() == 0) break;
      tick();
    end
    check("drain_empty", sb_q.size(), 0);
    check("no_stale", n_stale, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mul_round_pack.md
Name: fp_mul_round_pack

Overview:
- Final stage of the single-precision floating-point multiplier.
- Sits directly downstream of the exponent-add stage and the 24x24 mantissa multiplier.
- Consumes the biased exponent sum, the raw 48-bit significand product and the result sign.
- Normalises, rounds to nearest-even, detects overflow/underflow and packs the IEEE-754 word.
- Two-stage pipeline with valid/ready handshake so the multiplier can stall on downstream back-pressure.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 24, significand width including the hidden bit; product width is 2*MAN_W.
- BIAS, 127, exponent bias; used only for documentation and checks, since the exponent arrives already rebiased.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  stage can accept a beat.
- sign_in  in  1  result sign (sa ^ sb).
- exp_in  in  EXP_W+2  signed two's-complement biased exponent ea+eb-BIAS, before the normalise increment; range -127..383.
- man_in  in  2*MAN_W  unsigned significand product.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  EXP_W+MAN_W  packed {sign, exp, fraction}.
- flag_ovf  out  1  result overflowed to infinity.
- flag_unf  out  1  result underflowed and was flushed to signed zero.
- flag_inx  out  1  rounding discarded nonzero bits, or ovf, or unf.

Behaviour:
- Reset (synchronous, active-high, dominant over all other inputs):
  - Both pipe valids clear.
  - out_valid=0, result=0, all flags=0, in_ready=1 on the first cycle after reset.
- Handshake:
  - A beat transfers when valid&&ready.
  - in_ready = !s1_valid || s1_advance, where s1_advance = !s2_valid || out_ready.
  - Outputs hold stable while out_valid && !out_ready.
  - Full throughput of 1 beat/cycle when out_ready is held high.
  - No combinational path from in_valid to out_valid.
- Latency: 2 cycles from input acceptance to out_valid.
- S1 (normalise):
  - If man_in[47]: sig=man_in[47:24], guard=man_in[23], sticky=|man_in[22:0], exp=exp_in+1.
  - Else: sig=man_in[46:23], guard=man_in[22], sticky=|man_in[21:0], exp=exp_in.
  - Register sig, guard, sticky, exp and sign.
- S2 (round/pack):
  - RNE: inc = guard && (sticky || sig[0]).
  - sig+inc is computed at MAN_W+1 bits.
  - On carry-out: sig=1.000...0 and exp+=1.
  - inexact = guard || sticky.
- Range checks, applied after rounding:
  - exp >= 255: result={sign,8'hFF,0}, ovf=1, inx=1.
  - exp <= 0: result={sign,0,0}, unf=1, inx=1. No subnormals; flush-to-zero.
  - Otherwise: result={sign, exp[7:0], sig[22:0]}.
- Zero product (man_in==0):
  - Result is signed zero regardless of exp_in.
  - Flags all 0; this case takes precedence over the ovf/unf checks.
- Simultaneous accept in S1 and drain from S2 in the same cycle is legal; no bubble is inserted.
- Reset mid-operation discards all in-flight beats; no output is produced for them.

Optional Feature:
- Macro: FP_MUL_RTZ_EN.
- When defined:
  - Adds input port rnd_mode (1 bit; 0=RNE, 1=round-toward-zero), sampled with the beat and pipelined with it.
  - RTZ forces inc=0.
  - RTZ overflow saturates to the largest finite value {sign,8'hFE,23'h7FFFFF} with ovf=1.
- When undefined: no port is added and behaviour is RNE only.

Decomposition:
- Shared package fp_mul_pkg holds:
  - Constants EXP_W, MAN_W, BIAS, EXP_MAX=255.
  - Struct typedef for the S1 payload {sign, exp, sig, guard, sticky}.
  - Rounding-mode enum.
- One natural sub-module, fp_round_rne: the combinational round-increment and carry/exponent adjust.
- Pipeline registers and handshake stay in the top module.

Test Plan:
- Normal case: sign_in=0, exp_in=127, man_in=48'h9000_0000_0000 (1.5*1.5) -> result=32'h4010_0000 (2.25) after 2 cycles, flags 0.
- Tie round-up with carry: exp_in=127, man_in=48'h7FFF_FFC0_0000 -> sig rounds to 1.0 and exp becomes 128 -> result=32'h4000_0000, flag_inx=1.
- Overflow: exp_in=254, man_in[47]=1 -> result=32'h7F80_0000, flag_ovf=1, flag_inx=1; with FP_MUL_RTZ_EN and rnd_mode=1 -> 32'h7F7F_FFFF.
- Underflow and zero:
  - exp_in=0, sign_in=1, man_in=48'h4000_0000_0000 -> result=32'h8000_0000, flag_unf=1.
  - man_in=0 -> signed zero, all flags 0.
- Back-pressure: stream 4 beats with out_ready low for 3 cycles -> in_ready drops after 2 beats are accepted, outputs hold stable, then all 4 results emerge in order with no loss or duplication.
- Reset mid-stream: assert reset with both stages valid -> next cycle out_valid=0, result=0, in_ready=1, and no stale results are emitted afterwards.
